wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two sources: the in-order pipeline writeback (wb_regwen/wb_wdata from the writeback stage) and a long-latency unit (LU, e.g. mul/div or slow MMIO) returning results out of band.
- LU results are buffered in a small FIFO and drained in idle write slots.
- A starvation counter forces a drain by stalling the pipeline for one cycle.
- Scoreboard query ports report pending LU destinations so issue logic can interlock.

---
 rtl/wb_port_arbiter_if.sv | 55 +++++
 rtl/wb_port_arbiter.sv | 135 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Bundle of the pipeline writeback, long-latency-unit result,
//               scoreboard query and register-file write signals around the
//               write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if;
    // Pipeline writeback stage
    logic        pipe_regwen;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wdata;
    logic        pipe_stall;

    // Long-latency unit result return
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_wdata;
    logic        lu_ready;

    // Scoreboard queries from issue logic
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic [4:0]  q_rd;
    logic        q_rs1_busy;
    logic        q_rs2_busy;
    logic        q_rd_busy;

    // Register file write port
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    // Environment side: pipeline, LU, issue logic and register file
    modport master (
        output pipe_regwen, pipe_rd, pipe_wdata,
        output lu_valid, lu_rd, lu_wdata,
        output q_rs1, q_rs2, q_rd,
        input  pipe_stall, lu_ready,
        input  q_rs1_busy, q_rs2_busy, q_rd_busy,
        input  rf_wen, rf_rd, rf_wdata
    );

    // Arbiter side
    modport slave (
        input  pipe_regwen, pipe_rd, pipe_wdata,
        input  lu_valid, lu_rd, lu_wdata,
        input  q_rs1, q_rs2, q_rd,
        output pipe_stall, lu_ready,
        output q_rs1_busy, q_rs2_busy, q_rd_busy,
        output rf_wen, rf_rd, rf_wdata
    );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the single register-file write port between the
//               in-order pipeline writeback and a long-latency unit. LU
//               results wait in a small FIFO that drains in idle write
//               slots; a starvation counter steals one pipeline slot when
//               the FIFO has gone unserved for STARVE_LIMIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DEPTH        = 4,   // power of two, >= 2
    parameter int STARVE_LIMIT = 8    // >= 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    wb_port_arbiter_if.slave   bus
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [c_AW-1:0]  c_PTR_ONE    = c_AW'(1);
    localparam logic [c_CW-1:0]  c_CNT_ONE    = c_CW'(1);
    localparam logic [c_CW-1:0]  c_CNT_FULL   = c_CW'(DEPTH);
    localparam logic [c_SW-1:0]  c_STARVE_ONE = c_SW'(1);
    localparam logic [c_SW-1:0]  c_STARVE_MAX = c_SW'(STARVE_LIMIT);
    localparam logic [DEPTH-1:0] c_ONE_HOT    = DEPTH'(1);

    // FIFO storage; r_valid tracks occupied slots for the scoreboard lookup
    logic [4:0]       r_mem_rd   [DEPTH];
    logic [31:0]      r_mem_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [c_SW-1:0]  r_starve;

    logic             w_empty;
    logic             w_full;
    logic             w_pipe_used;
    logic             w_force;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_push_mask;
    logic [DEPTH-1:0] w_pop_mask;
    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic             w_rd_hit;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_CNT_FULL);
    assign w_pipe_used = bus.pipe_regwen && (bus.pipe_rd != 5'd0);
    assign w_force     = (r_starve == c_STARVE_MAX) && !w_empty;

    // Ready depends only on registered occupancy, never on a same-cycle pop
    assign bus.lu_ready = !rst && !w_full;

    // Results for x0 complete the handshake but are dropped
    assign w_push      = bus.lu_valid && bus.lu_ready && (bus.lu_rd != 5'd0);
    assign w_push_mask = w_push ? (c_ONE_HOT << r_wr_ptr) : '0;
    assign w_pop_mask  = w_pop  ? (c_ONE_HOT << r_rd_ptr) : '0;

    // Write-port selection: forced drain, then pipeline, then idle-slot drain
    always_comb begin
        bus.rf_wen     = 1'b0;
        bus.rf_rd      = bus.pipe_rd;
        bus.rf_wdata   = bus.pipe_wdata;
        bus.pipe_stall = 1'b0;
        w_pop          = 1'b0;
        if (!rst) begin
            if (w_force) begin
                bus.rf_wen     = 1'b1;
                bus.rf_rd      = r_mem_rd[r_rd_ptr];
                bus.rf_wdata   = r_mem_data[r_rd_ptr];
                bus.pipe_stall = 1'b1;
                w_pop          = 1'b1;
            end else if (w_pipe_used) begin
                bus.rf_wen     = 1'b1;
            end else if (!w_empty) begin
                bus.rf_wen     = 1'b1;
                bus.rf_rd      = r_mem_rd[r_rd_ptr];
                bus.rf_wdata   = r_mem_data[r_rd_ptr];
                w_pop          = 1'b1;
            end
        end
    end

    // Scoreboard: match each query against every occupied entry, head included
    always_comb begin
        w_rs1_hit = 1'b0;
        w_rs2_hit = 1'b0;
        w_rd_hit  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_mem_rd[i] == bus.q_rs1)) w_rs1_hit = 1'b1;
            if (r_valid[i] && (r_mem_rd[i] == bus.q_rs2)) w_rs2_hit = 1'b1;
            if (r_valid[i] && (r_mem_rd[i] == bus.q_rd))  w_rd_hit  = 1'b1;
        end
    end

    assign bus.q_rs1_busy = !rst && (bus.q_rs1 != 5'd0) && w_rs1_hit;
    assign bus.q_rs2_busy = !rst && (bus.q_rs2 != 5'd0) && w_rs2_hit;
    assign bus.q_rd_busy  = !rst && (bus.q_rd  != 5'd0) && w_rd_hit;

    // FIFO payload write; contents are qualified by r_valid so need no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= bus.lu_rd;
            r_mem_data[r_wr_ptr] <= bus.lu_wdata;
        end
    end

    // FIFO control state and starvation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            r_starve <= '0;
        end else begin
            r_valid <= (r_valid & ~w_pop_mask) | w_push_mask;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + c_CNT_ONE;
            else if (!w_push && w_pop) r_count <= r_count - c_CNT_ONE;
            // A forced drain resets the count, so the next force needs a fresh run
            if (w_empty || w_pop)               r_starve <= '0;
            else if (r_starve != c_STARVE_MAX)  r_starve <= r_starve + c_STARVE_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed self-checking bench for wb_port_arbiter
//               (DEPTH=4, STARVE_LIMIT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(
        .DEPTH        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic en, input logic [4:0] rd, input logic [31:0] d);
        bus.pipe_regwen = en;
        bus.pipe_rd     = rd;
        bus.pipe_wdata  = d;
    endtask

    task automatic set_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.lu_valid = v;
        bus.lu_rd    = rd;
        bus.lu_wdata = d;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst      = 1'b1;
        set_pipe(1'b1, 5'd3, 32'h1234);
        set_lu(1'b0, 5'd0, 32'h0);
        bus.q_rs1 = 5'd0;
        bus.q_rs2 = 5'd0;
        bus.q_rd  = 5'd0;

        // Reset state: outputs held quiet even with a live pipeline write
        #2;
        chk("rst_rf_wen",   32'(bus.rf_wen),     32'd0);
        chk("rst_lu_ready", 32'(bus.lu_ready),   32'd0);
        chk("rst_stall",    32'(bus.pipe_stall), 32'd0);
        tick();
        rst = 1'b0;
        set_pipe(1'b0, 5'd0, 32'h0);
        #1;
        chk("post_rst_lu_ready", 32'(bus.lu_ready), 32'd1);
        chk("post_rst_rf_wen",   32'(bus.rf_wen),   32'd0);

        // Priority: pipeline wins while busy, FIFO drains on first idle slot
        tick();
        set_pipe(1'b1, 5'd3, 32'h1234);
        set_lu(1'b1, 5'd5, 32'hAAAA_0001);
        bus.q_rs1 = 5'd5;
        #1;
        chk("prio_push_rd", 32'(bus.rf_rd), 32'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            set_lu(1'b0, 5'd0, 32'h0);
            #1;
            chk("prio_pipe_wen",   32'(bus.rf_wen),     32'd1);
            chk("prio_pipe_rd",    32'(bus.rf_rd),      32'd3);
            chk("prio_pipe_data",  bus.rf_wdata,        32'h1234);
            chk("prio_pipe_stall", 32'(bus.pipe_stall), 32'd0);
            chk("prio_busy5",      32'(bus.q_rs1_busy), 32'd1);
        end
        tick();
        set_pipe(1'b0, 5'd0, 32'h0);
        #1;
        chk("prio_drain_wen",  32'(bus.rf_wen), 32'd1);
        chk("prio_drain_rd",   32'(bus.rf_rd),  32'd5);
        chk("prio_drain_data", bus.rf_wdata,    32'hAAAA_0001);
        tick();
        #1;
        chk("prio_empty_wen", 32'(bus.rf_wen),     32'd0);
        chk("prio_busy_clr",  32'(bus.q_rs1_busy), 32'd0);

        // Starvation: 8 unserved cycles, then one forced drain
        tick();
        set_pipe(1'b1, 5'd3, 32'h1234);
        set_lu(1'b1, 5'd7, 32'h77);
        #1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            set_lu(1'b0, 5'd0, 32'h0);
            #1;
            chk("starve_wait_stall", 32'(bus.pipe_stall), 32'd0);
            chk("starve_wait_rd",    32'(bus.rf_rd),      32'd3);
        end
        tick();
        #1;
        chk("force_stall", 32'(bus.pipe_stall), 32'd1);
        chk("force_wen",   32'(bus.rf_wen),     32'd1);
        chk("force_rd",    32'(bus.rf_rd),      32'd7);
        chk("force_data",  bus.rf_wdata,        32'h77);
        tick();
        #1;
        chk("after_force_stall", 32'(bus.pipe_stall), 32'd0);
        chk("after_force_rd",    32'(bus.rf_rd),      32'd3);

        // Full backpressure with pipe busy
        for (int i = 0; i < 4; i++) begin
            tick();
            set_lu(1'b1, 5'(i + 1), 32'h100 + 32'(i));
            #1;
            chk("fill_lu_ready", 32'(bus.lu_ready), 32'd1);
        end
        tick();
        set_pipe(1'b0, 5'd0, 32'h0);
        set_lu(1'b1, 5'd5, 32'h105);
        #1;
        chk("full_lu_ready", 32'(bus.lu_ready), 32'd0);
        chk("full_pop_rd",   32'(bus.rf_rd),    32'd1);
        chk("full_pop_data", bus.rf_wdata,      32'h100);
        tick();
        set_pipe(1'b1, 5'd3, 32'h1234);
        set_lu(1'b0, 5'd0, 32'h0);
        #1;
        chk("refill_lu_ready", 32'(bus.lu_ready), 32'd1);
        chk("refill_pipe_rd",  32'(bus.rf_rd),    32'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            set_pipe(1'b0, 5'd0, 32'h0);
            #1;
            chk("full_drain_rd",   32'(bus.rf_rd), 32'(i + 2));
            chk("full_drain_data", bus.rf_wdata,   32'h101 + 32'(i));
        end
        tick();
        #1;
        chk("full_empty_wen", 32'(bus.rf_wen), 32'd0);

        // x0 handling
        tick();
        set_lu(1'b1, 5'd0, 32'hDEAD);
        bus.q_rd = 5'd0;
        #1;
        chk("x0_lu_ready", 32'(bus.lu_ready),  32'd1);
        chk("x0_q_busy",   32'(bus.q_rd_busy), 32'd0);
        tick();
        set_lu(1'b1, 5'd6, 32'h66);
        #1;
        chk("x0_not_pushed", 32'(bus.rf_wen), 32'd0);
        tick();
        set_lu(1'b0, 5'd0, 32'h0);
        set_pipe(1'b1, 5'd0, 32'h999);
        bus.q_rs1 = 5'd6;
        #1;
        chk("x0_pipe_wen",   32'(bus.rf_wen),     32'd1);
        chk("x0_pipe_rd",    32'(bus.rf_rd),      32'd6);
        chk("x0_pipe_data",  bus.rf_wdata,        32'h66);
        chk("x0_head_busy",  32'(bus.q_rs1_busy), 32'd1);
        chk("x0_q0_busy",    32'(bus.q_rd_busy),  32'd0);
        tick();
        set_pipe(1'b0, 5'd0, 32'h0);
        #1;
        chk("x0_empty_wen",  32'(bus.rf_wen),     32'd0);
        chk("x0_busy_clr",   32'(bus.q_rs1_busy), 32'd0);

        // Scoreboard
        tick();
        set_pipe(1'b1, 5'd3, 32'h1234);
        set_lu(1'b1, 5'd9, 32'h9);
        tick();
        set_lu(1'b1, 5'd12, 32'hC);
        tick();
        set_lu(1'b0, 5'd0, 32'h0);
        bus.q_rs1 = 5'd9;
        bus.q_rs2 = 5'd12;
        bus.q_rd  = 5'd4;
        #1;
        chk("sb_rs1_busy", 32'(bus.q_rs1_busy), 32'd1);
        chk("sb_rs2_busy", 32'(bus.q_rs2_busy), 32'd1);
        chk("sb_rd_busy",  32'(bus.q_rd_busy),  32'd0);
        tick();
        set_pipe(1'b0, 5'd0, 32'h0);
        #1;
        chk("sb_drain1_rd", 32'(bus.rf_rd), 32'd9);
        tick();
        #1;
        chk("sb_drain2_rd", 32'(bus.rf_rd), 32'd12);
        tick();
        #1;
        chk("sb_rs1_clr", 32'(bus.q_rs1_busy), 32'd0);
        chk("sb_rs2_clr", 32'(bus.q_rs2_busy), 32'd0);
        chk("sb_rd_clr",  32'(bus.q_rd_busy),  32'd0);
        chk("sb_wen_clr", 32'(bus.rf_wen),     32'd0);

        // Wrap: simultaneous push/pop keeps LU completion order
        for (int k = 0; k < 10; k++) begin
            tick();
            set_lu(1'b1, 5'(10 + k), 32'hC0 + 32'(k));
            #1;
            chk("wrap_lu_ready", 32'(bus.lu_ready), 32'd1);
            if (k > 0) begin
                chk("wrap_rd",   32'(bus.rf_rd), 32'(10 + k - 1));
                chk("wrap_data", bus.rf_wdata,   32'hC0 + 32'(k - 1));
            end
        end
        tick();
        set_lu(1'b0, 5'd0, 32'h0);
        #1;
        chk("wrap_last_rd",   32'(bus.rf_rd), 32'd19);
        chk("wrap_last_data", bus.rf_wdata,   32'hC9);
        tick();
        #1;
        chk("wrap_empty_wen", 32'(bus.rf_wen), 32'd0);

        // Reset mid-operation: 3 entries held, starve counter at 5
        bus.q_rs1 = 5'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            set_pipe(1'b1, 5'd3, 32'h1234);
            set_lu(1'b1, 5'(i + 1), 32'h200 + 32'(i));
        end
        tick();
        set_lu(1'b0, 5'd0, 32'h0);
        tick();
        tick();
        tick();
        #1;
        chk("pre_rst_busy",  32'(bus.q_rs1_busy), 32'd1);
        chk("pre_rst_stall", 32'(bus.pipe_stall), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_wen",   32'(bus.rf_wen),     32'd0);
        chk("mid_rst_ready", 32'(bus.lu_ready),   32'd0);
        chk("mid_rst_busy",  32'(bus.q_rs1_busy), 32'd0);
        chk("mid_rst_stall", 32'(bus.pipe_stall), 32'd0);
        tick();
        rst = 1'b0;
        set_pipe(1'b0, 5'd0, 32'h0);
        #1;
        chk("rel_lu_ready", 32'(bus.lu_ready),   32'd1);
        chk("rel_wen",      32'(bus.rf_wen),     32'd0);
        chk("rel_busy",     32'(bus.q_rs1_busy), 32'd0);
        tick();
        #1;
        chk("rel_no_stale", 32'(bus.rf_wen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
